// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file: two write ports, NUM_RD registered read
// ports with write-to-read bypass, hardwired zero entry and a one-entry-per-cycle clear sweep.
module regfile_mp #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 5,
  parameter int          NUM_RD  = 2,
  parameter int          SP_ADDR = 29,
  parameter int unsigned SP_INIT = 252
) (
  input  logic                       elk,
  input  logic                       nrst,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       clr_done,
  output logic                       wr_drop
);

  localparam int                DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] SP_IDX = ADDR_W'(SP_ADDR);
  localparam logic [ADDR_W-1:0] LAST   = '1;
  localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_INIT);

  typedef enum logic {S_IDLE, S_SWEEP} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          idx_q, idx_d;
  logic [DATA_W-1:0]          mem_q [DEPTH];
  logic [DATA_W-1:0]          mem_d [DEPTH];
  logic                       clr_done_q, clr_done_d;
  logic                       wr_drop_q, wr_drop_d;
  logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                       sweeping, we0, we1;
  logic [DATA_W-1:0]          sweep_val;

  function automatic logic [DATA_W-1:0] clear_value(input logic [ADDR_W-1:0] a);
    return (a == SP_IDX) ? SP_VAL : '0;
  endfunction

  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      idx_q      <= ADDR_W'(1);
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_done_q <= clr_done_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_SWEEP;
          idx_d   = ADDR_W'(1);
        end
      end
      S_SWEEP: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sweeping   = (state_q == S_SWEEP);
    we0        = !sweeping && wr0_en && (wr0_addr != '0);
    we1        = !sweeping && wr1_en && (wr1_addr != '0);
    sweep_val  = clear_value(idx_q);
    clr_done_d = sweeping && (idx_q == LAST);
    wr_drop_d  = sweeping && ((wr0_en && (wr0_addr != '0)) || (wr1_en && (wr1_addr != '0)));
  end

  // Post-edge array image; port 1 is applied last so it wins a same-address collision.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) mem_d[j] = mem_q[j];
    if (sweeping) mem_d[idx_q]    = sweep_val;
    if (we0)      mem_d[wr0_addr] = wr0_data;
    if (we1)      mem_d[wr1_addr] = wr1_data;
    mem_d[0] = '0;
  end

  // Reading the post-edge image gives the bypass for free, including address 0 -> 0.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_RD; i++)
      rd_data_d[i*DATA_W +: DATA_W] = mem_d[rd_addr[i*ADDR_W +: ADDR_W]];
  end

  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= (j == SP_ADDR) ? SP_VAL : '0;
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign busy     = (state_q == S_SWEEP);
  assign clr_done = clr_done_q;
  assign wr_drop  = wr_drop_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against an array-level model of the register file.
module tb_regfile_mp;

  localparam int          DW    = 32;
  localparam int          AW    = 5;
  localparam int          NR    = 2;
  localparam int          DEPTH = 32;
  localparam int          SPA   = 29;
  localparam logic [31:0] SPV   = 32'd252;

  logic              elk = 1'b0;
  logic              nrst = 1'b1;
  logic              wr0_en, wr1_en, clr_req;
  logic [AW-1:0]     wr0_addr, wr1_addr;
  logic [DW-1:0]     wr0_data, wr1_data;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic              busy, clr_done, wr_drop;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_mem [DEPTH];
  bit          m_busy;
  int          m_idx;
  logic [31:0] e_rd [NR];
  bit          e_done, e_drop;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .SP_ADDR(SPA), .SP_INIT(252)) dut (
    .elk(elk), .nrst(nrst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop)
  );

  always #5 elk = ~elk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int j = 0; j < DEPTH; j++) m_mem[j] = (j == SPA) ? SPV : 32'd0;
    m_busy = 1'b0;
    m_idx  = 1;
    for (int p = 0; p < NR; p++) e_rd[p] = 32'd0;
    e_done = 1'b0;
    e_drop = 1'b0;
  endfunction

  // One clock edge of the register file: commit writes or one sweep entry, then every
  // read port sees the array as it stands after the edge.
  function automatic void model_step();
    int a0, a1;
    if (!nrst) return;
    a0 = int'(wr0_addr);
    a1 = int'(wr1_addr);
    e_done = 1'b0;
    e_drop = 1'b0;
    if (!m_busy) begin
      if (wr0_en && a0 != 0) m_mem[a0] = wr0_data;
      if (wr1_en && a1 != 0) m_mem[a1] = wr1_data;
      if (clr_req) begin
        m_busy = 1'b1;
        m_idx  = 1;
      end
    end else begin
      if ((wr0_en && a0 != 0) || (wr1_en && a1 != 0)) e_drop = 1'b1;
      m_mem[m_idx] = (m_idx == SPA) ? SPV : 32'd0;
      if (m_idx == DEPTH-1) begin
        m_busy = 1'b0;
        e_done = 1'b1;
      end
      m_idx++;
    end
    for (int p = 0; p < NR; p++) e_rd[p] = m_mem[int'(rd_addr[p*AW +: AW])];
  endfunction

  always @(negedge elk) begin
    if (chk_en) begin
      for (int p = 0; p < NR; p++)
        cmp($sformatf("rd%0d", p), rd_data[p*DW +: DW], e_rd[p]);
      cmp("busy", 32'(busy), 32'(m_busy));
      cmp("clr_done", 32'(clr_done), 32'(e_done));
      cmp("wr_drop", 32'(wr_drop), 32'(e_drop));
    end
  end

  task automatic drive(input bit w0e, input int w0a, input logic [31:0] w0d,
                       input bit w1e, input int w1a, input logic [31:0] w1d,
                       input int r0, input int r1, input bit clr);
    wr0_en   = w0e;
    wr0_addr = AW'(w0a);
    wr0_data = w0d;
    wr1_en   = w1e;
    wr1_addr = AW'(w1a);
    wr1_data = w1d;
    rd_addr  = {AW'(r1), AW'(r0)};
    clr_req  = clr;
  endtask

  task automatic tick();
    @(posedge elk);
    model_step();
    #1;
  endtask

  task automatic idle(input int r0, input int r1);
    drive(0, 0, 32'd0, 0, 0, 32'd0, r0, r1, 0);
    tick();
  endtask

  initial begin
    int nb, nd;
    bit fell;
    int a0, a1;

    drive(0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0);
    #3 nrst = 1'b0;
    model_reset();
    #1;
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_rd0", rd_data[31:0], 32'd0);
    cmp("rst_rd1", rd_data[63:32], 32'd0);
    repeat (2) @(posedge elk);
    @(negedge elk);
    nrst   = 1'b1;
    chk_en = 1'b1;

    // Reset contents: stack pointer and an ordinary entry
    idle(29, 5);
    cmp("t1_sp", rd_data[31:0], 32'h0000_00FC);
    cmp("t1_r5", rd_data[63:32], 32'h0000_0000);

    // Write then read, and the zero register
    drive(1, 7, 32'hDEAD_BEEF, 0, 0, 32'd0, 7, 0, 0); tick();
    cmp("t2_bypass", rd_data[31:0], 32'hDEAD_BEEF);
    idle(7, 0);
    cmp("t2_r7", rd_data[31:0], 32'hDEAD_BEEF);
    drive(1, 0, 32'h1234_5678, 0, 0, 32'd0, 0, 0, 0); tick();
    cmp("t2_r0_byp", rd_data[31:0], 32'd0);
    idle(0, 7);
    cmp("t2_r0", rd_data[31:0], 32'd0);
    cmp("t2_nodrop", 32'(wr_drop), 32'd0);

    // Collision on one edge: port 1 wins, visible through the bypass
    drive(1, 3, 32'h1111_1111, 1, 3, 32'h2222_2222, 3, 0, 0); tick();
    cmp("t3_byp", rd_data[31:0], 32'h2222_2222);
    idle(3, 3);
    cmp("t3_r3", rd_data[31:0], 32'h2222_2222);
    cmp("t3_r3p1", rd_data[63:32], 32'h2222_2222);

    // Clear sweep with a second request mid-sweep
    drive(1, 1, 32'hA, 1, 29, 32'h5, 1, 29, 0); tick();
    drive(1, 31, 32'hB, 0, 0, 32'd0, 31, 29, 0); tick();
    cmp("t4_r31pre", rd_data[31:0], 32'hB);
    cmp("t4_r29pre", rd_data[63:32], 32'h5);
    drive(0, 0, 32'd0, 0, 0, 32'd0, 29, 1, 1); tick();
    cmp("t4_busy_on", 32'(busy), 32'd1);
    nb = 1; nd = 0; fell = 1'b0;
    for (int n = 0; n < 40 && !fell; n++) begin
      drive(0, 0, 32'd0, 0, 0, 32'd0, 29, 1, (n == 5));
      tick();
      if (clr_done) nd++;
      if (busy) nb++;
      else fell = 1'b1;
    end
    cmp("t4_fell", 32'(fell), 32'd1);
    cmp("t4_busy_cycles", nb, 32'd31);
    cmp("t4_done_cnt", nd, 32'd1);
    cmp("t4_done_at_fall", 32'(clr_done), 32'd1);
    idle(1, 29);
    cmp("t4_r1", rd_data[31:0], 32'd0);
    cmp("t4_r29", rd_data[63:32], 32'h0000_00FC);
    idle(31, 0);
    cmp("t4_r31", rd_data[31:0], 32'd0);

    // Write during sweep is dropped
    drive(1, 20, 32'h77, 0, 0, 32'd0, 20, 0, 0); tick();
    drive(0, 0, 32'd0, 0, 0, 32'd0, 20, 0, 1); tick();
    idle(20, 0);
    idle(20, 0);
    drive(1, 20, 32'h55, 0, 0, 32'd0, 20, 0, 0); tick();
    cmp("t5_drop", 32'(wr_drop), 32'd1);
    cmp("t5_r20_kept", rd_data[31:0], 32'h77);
    idle(20, 0);
    cmp("t5_drop_once", 32'(wr_drop), 32'd0);
    cmp("t5_r20_mid", rd_data[31:0], 32'h77);
    for (int n = 0; n < 40 && busy; n++) idle(20, 0);
    cmp("t5_idle", 32'(busy), 32'd0);
    idle(20, 0);
    cmp("t5_r20", rd_data[31:0], 32'd0);

    // Reset in the middle of a sweep
    drive(1, 30, 32'h33, 1, 2, 32'h99, 29, 30, 0); tick();
    drive(0, 0, 32'd0, 0, 0, 32'd0, 29, 30, 1); tick();
    repeat (9) idle(29, 30);
    cmp("t6_busy_pre", 32'(busy), 32'd1);
    #2 nrst = 1'b0;
    model_reset();
    #1;
    cmp("t6_busy", 32'(busy), 32'd0);
    cmp("t6_rd0", rd_data[31:0], 32'd0);
    cmp("t6_rd1", rd_data[63:32], 32'd0);
    cmp("t6_done", 32'(clr_done), 32'd0);
    tick();
    @(negedge elk);
    nrst = 1'b1;
    idle(29, 2);
    cmp("t6_sp", rd_data[31:0], 32'h0000_00FC);
    cmp("t6_r2", rd_data[63:32], 32'd0);
    idle(30, 0);
    cmp("t6_r30", rd_data[31:0], 32'd0);
    cmp("t6_nodone", 32'(clr_done), 32'd0);

    // Randomized traffic
    repeat (500) begin
      a0 = int'($urandom_range(0, DEPTH-1));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, DEPTH-1));
      drive(1'($urandom_range(0, 1)), a0, $urandom,
            1'($urandom_range(0, 1)), a1, $urandom,
            ($urandom_range(0, 1) == 0) ? a0 : int'($urandom_range(0, DEPTH-1)),
            ($urandom_range(0, 1) == 0) ? a1 : int'($urandom_range(0, DEPTH-1)),
            ($urandom_range(0, 39) == 0));
      tick();
    end
    for (int n = 0; n < 40 && busy; n++) idle(0, 0);
    for (int j = 0; j < DEPTH; j += 2) idle(j, j + 1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, want finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
